// File: rtl/text_pkg.sv
// Shared definitions for the text console: screen geometry, control codes,
// glyph constants, FSM state encoding and the cell-address helper.
package text_pkg;

  localparam int unsigned COLS   = 40;            // characters per row
  localparam int unsigned ROWS   = 30;            // character rows
  localparam int unsigned CELLS  = COLS * ROWS;   // cell memory depth
  localparam int unsigned ADDR_W = 11;            // cell address width
  localparam int unsigned GLYPHS = 96;            // font glyph count

  typedef logic [ADDR_W-1:0] addr_t;

  // Control codes
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;

  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] ASCII_BASE  = 8'h20;

  // FSM state encoding
  localparam logic [2:0] StClear       = 3'd0;
  localparam logic [2:0] StIdle        = 3'd1;
  localparam logic [2:0] StPut         = 3'd2;
  localparam logic [2:0] StScrollRd    = 3'd3;
  localparam logic [2:0] StScrollWr    = 3'd4;
  localparam logic [2:0] StScrollBlank = 3'd5;

  // Linear cell address row*COLS+col, computed entirely in ADDR_W bits.
  function automatic addr_t cell_addr(input logic [4:0] row, input logic [6:0] col);
    return addr_t'(row) * addr_t'(COLS) + addr_t'(col);
  endfunction

endpackage

// File: rtl/text_console_if.sv
// Console bus bundle: byte-stream input handshake, renderer read port and
// status outputs.
//   slave  : the console side (text_console)
//   master : the producer / renderer side
interface text_console_if;

  logic [7:0]                  in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [text_pkg::ADDR_W-1:0] rd_addr;
  logic [7:0]                  rd_data;
  logic [6:0]                  cursor_col;
  logic [4:0]                  cursor_row;
  logic                        busy;
  logic                        redraw;

  modport slave (
    input  in_data, in_valid, rd_addr,
    output in_ready, rd_data, cursor_col, cursor_row, busy, redraw
  );

  modport master (
    output in_data, in_valid, rd_addr,
    input  in_ready, rd_data, cursor_col, cursor_row, busy, redraw
  );

endinterface

// File: rtl/char_ram.sv
// Simple dual-port CELLS x 8 cell memory.
//   clk_i               : clock
//   a_we_i/a_addr_i     : port A write enable / address (FSM side)
//   a_wdata_i/a_rdata_o : port A write data / registered read data
//   b_addr_i/b_rdata_o  : port B address / registered read data (renderer)
// Contents are not reset.
module char_ram
  import text_pkg::*;
(
  input  logic       clk_i,
  input  logic       a_we_i,
  input  addr_t      a_addr_i,
  input  logic [7:0] a_wdata_i,
  output logic [7:0] a_rdata_o,
  input  addr_t      b_addr_i,
  output logic [7:0] b_rdata_o
);

  logic [7:0] mem_q [CELLS];

  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
    a_rdata_o <= mem_q[a_addr_i];
    b_rdata_o <= mem_q[b_addr_i];
  end

endmodule

// File: rtl/text_console.sv
// Character-cell text console. Consumes a byte stream, tracks a cursor and
// writes glyph indices into a COLS x ROWS cell memory read by the renderer.
//   clk_sys    : system clock
//   reset_n    : asynchronous active-low reset
//   bus.slave  : in_data/in_valid/in_ready byte handshake, rd_addr/rd_data
//                renderer port (1-cycle latency), cursor_col/cursor_row,
//                busy, redraw (one-cycle pulse after a visible change)
module text_console
  import text_pkg::*;
(
  input  logic          clk_sys,
  input  logic          reset_n,
  text_console_if.slave bus
);

  logic [2:0] state_q, state_d;
  logic [6:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  addr_t      ptr_q, ptr_d;
  logic [7:0] glyph_q, glyph_d;
  logic       bs_q, bs_d;         // PUT is erasing after a backspace: no advance
  logic       redraw_q, redraw_d;
  logic       boot_q, boot_d;     // clear in progress is the post-reset one
  logic       rd_ok_q;            // renderer address was inside the memory

  logic       a_we;
  addr_t      a_addr;
  logic [7:0] a_wdata, a_rdata, b_rdata;

  logic [7:0] glyph_c;
  logic       is_print, last_col, last_row;

  assign glyph_c  = bus.in_data - ASCII_BASE;
  assign is_print = (bus.in_data >= ASCII_BASE) && (glyph_c < 8'(GLYPHS));
  assign last_col = (col_q == 7'(COLS - 1));
  assign last_row = (row_q == 5'(ROWS - 1));

  char_ram u_ram (
    .clk_i     (clk_sys),
    .a_we_i    (a_we),
    .a_addr_i  (a_addr),
    .a_wdata_i (a_wdata),
    .a_rdata_o (a_rdata),
    .b_addr_i  (bus.rd_addr),
    .b_rdata_o (b_rdata)
  );

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    ptr_d    = ptr_q;
    glyph_d  = glyph_q;
    bs_d     = bs_q;
    boot_d   = boot_q;
    redraw_d = 1'b0;
    a_we     = 1'b0;
    a_addr   = ptr_q;
    a_wdata  = GLYPH_BLANK;

    case (state_q)
      StClear: begin
        a_we = 1'b1;
        if (ptr_q == addr_t'(CELLS - 1)) begin
          ptr_d    = '0;
          state_d  = StIdle;
          redraw_d = !boot_q;
          boot_d   = 1'b0;
        end else begin
          ptr_d = ptr_q + addr_t'(1);
        end
      end

      StIdle: begin
        if (bus.in_valid) begin
          if (is_print) begin
            glyph_d = glyph_c;
            bs_d    = 1'b0;
            state_d = StPut;
          end else begin
            case (bus.in_data)
              CR: begin
                col_d    = '0;
                redraw_d = 1'b1;
              end
              LF: begin
                col_d = '0;
                if (!last_row) begin
                  row_d    = row_q + 5'd1;
                  redraw_d = 1'b1;
                end else begin
                  ptr_d   = '0;
                  state_d = StScrollRd;
                end
              end
              BS: begin
                // Step back and let PUT blank the new position.
                if (col_q != '0) begin
                  col_d   = col_q - 7'd1;
                  glyph_d = GLYPH_BLANK;
                  bs_d    = 1'b1;
                  state_d = StPut;
                end
              end
              FF: begin
                col_d   = '0;
                row_d   = '0;
                ptr_d   = '0;
                state_d = StClear;
              end
              default: ;
            endcase
          end
        end
      end

      StPut: begin
        a_we     = 1'b1;
        a_addr   = cell_addr(row_q, col_q);
        a_wdata  = glyph_q;
        state_d  = StIdle;
        redraw_d = 1'b1;
        if (!bs_q) begin
          if (!last_col) begin
            col_d = col_q + 7'd1;
          end else begin
            col_d = '0;
            if (!last_row) begin
              row_d = row_q + 5'd1;
            end else begin
              // Redraw is deferred until the scroll completes.
              ptr_d    = '0;
              state_d  = StScrollRd;
              redraw_d = 1'b0;
            end
          end
        end
      end

      StScrollRd: begin
        a_addr  = ptr_q + addr_t'(COLS);
        state_d = StScrollWr;
      end

      StScrollWr: begin
        a_we    = 1'b1;
        a_wdata = a_rdata;
        ptr_d   = ptr_q + addr_t'(1);
        // ptr_q+1 is then the first cell of the bottom row.
        if (ptr_q == addr_t'(CELLS - COLS - 1)) begin
          state_d = StScrollBlank;
        end else begin
          state_d = StScrollRd;
        end
      end

      StScrollBlank: begin
        a_we = 1'b1;
        if (ptr_q == addr_t'(CELLS - 1)) begin
          ptr_d    = '0;
          state_d  = StIdle;
          redraw_d = 1'b1;
        end else begin
          ptr_d = ptr_q + addr_t'(1);
        end
      end

      default: begin
        ptr_d   = '0;
        state_d = StClear;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StClear;
      col_q    <= '0;
      row_q    <= '0;
      ptr_q    <= '0;
      glyph_q  <= '0;
      bs_q     <= 1'b0;
      boot_q   <= 1'b1;
      redraw_q <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      ptr_q    <= ptr_d;
      glyph_q  <= glyph_d;
      bs_q     <= bs_d;
      boot_q   <= boot_d;
      redraw_q <= redraw_d;
      rd_ok_q  <= (bus.rd_addr < addr_t'(CELLS));
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.redraw     = redraw_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
  assign bus.rd_data    = rd_ok_q ? b_rdata : 8'h00;

endmodule

// File: tb/tb_text_console.sv
// Randomised, scoreboard-checked bench for text_console. A screen model kept
// as a plain array predicts cell contents, cursor and busy time; expected
// redraw cursors are queued and popped by a monitor on every redraw pulse.
module tb_text_console;
  import text_pkg::*;

  logic clk_sys = 1'b0;
  logic reset_n;

  text_console_if bus ();

  text_console dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int col;
    int row;
  } cur_t;

  cur_t       sb_q[$];
  logic [7:0] mdl_mem [CELLS];
  int         mdl_col;
  int         mdl_row;

  function automatic void check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic void mdl_clear();
    for (int i = 0; i < CELLS; i++) mdl_mem[i] = 8'h00;
    mdl_col = 0;
    mdl_row = 0;
  endfunction

  function automatic void mdl_scroll();
    for (int i = 0; i < CELLS - COLS; i++) mdl_mem[i] = mdl_mem[i + COLS];
    for (int i = CELLS - COLS; i < CELLS; i++) mdl_mem[i] = 8'h00;
  endfunction

  // Applies one byte; returns busy cycles, flags whether a redraw follows.
  function automatic int mdl_apply(input logic [7:0] b, output bit redraw);
    int cyc;
    cyc    = 0;
    redraw = 1'b0;
    if (b >= 8'h20 && b <= 8'h7F) begin
      mdl_mem[mdl_row * COLS + mdl_col] = b - 8'h20;
      cyc    = 1;
      redraw = 1'b1;
      mdl_col++;
      if (mdl_col == COLS) begin
        mdl_col = 0;
        if (mdl_row == ROWS - 1) begin
          mdl_scroll();
          cyc += 2 * (CELLS - COLS) + COLS;
        end else begin
          mdl_row++;
        end
      end
    end else if (b == 8'h0D) begin
      mdl_col = 0;
      redraw  = 1'b1;
    end else if (b == 8'h0A) begin
      mdl_col = 0;
      redraw  = 1'b1;
      if (mdl_row == ROWS - 1) begin
        mdl_scroll();
        cyc = 2 * (CELLS - COLS) + COLS;
      end else begin
        mdl_row++;
      end
    end else if (b == 8'h08) begin
      if (mdl_col > 0) begin
        mdl_col--;
        mdl_mem[mdl_row * COLS + mdl_col] = 8'h00;
        cyc    = 1;
        redraw = 1'b1;
      end
    end else if (b == 8'h0C) begin
      mdl_clear();
      cyc    = CELLS;
      redraw = 1'b1;
    end
    return cyc;
  endfunction

  // ---------------- redraw monitor ----------------
  always @(negedge clk_sys) begin : mon
    cur_t e;
    if (reset_n === 1'b1 && bus.redraw === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("redraw_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("redraw_col", bus.cursor_col, e.col);
        check("redraw_row", bus.cursor_row, e.row);
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send(input logic [7:0] b);
    int cnt;
    int exp_cyc;
    bit rd;
    cnt = 0;
    while (bus.in_ready !== 1'b1 && cnt < 5000) begin
      @(negedge clk_sys);
      cnt++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    exp_cyc = mdl_apply(b, rd);
    if (rd) sb_q.push_back(cur_t'{mdl_col, mdl_row});
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk_sys);
    bus.in_valid = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 5000) begin
      @(negedge clk_sys);
      cnt++;
    end
    check($sformatf("busy_cycles_byte_%02h", b), cnt, exp_cyc);
    @(negedge clk_sys);
    check("redraw_missing", sb_q.size(), 0);
  endtask

  task automatic read_cell(input int a, output logic [7:0] d);
    bus.rd_addr = addr_t'(a);
    @(negedge clk_sys);
    d = bus.rd_data;
  endtask

  task automatic check_mem(input string name);
    int bad;
    int first;
    logic [7:0] d;
    bad   = 0;
    first = -1;
    for (int a = 0; a < CELLS; a++) begin
      read_cell(a, d);
      if (d !== mdl_mem[a]) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    check($sformatf("%s bad cells (first at %0d)", name, first), bad, 0);
  endtask

  task automatic check_cursor(input string name);
    check({name, "_col"}, bus.cursor_col, mdl_col);
    check({name, "_row"}, bus.cursor_row, mdl_row);
  endtask

  task automatic wait_clear(input string name);
    int cnt;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 5000) begin
      @(negedge clk_sys);
      cnt++;
    end
    check(name, cnt, CELLS);
  endtask

  function automatic logic [7:0] rand_byte();
    int unsigned r;
    logic [7:0]  b;
    r = $urandom_range(0, 99);
    if (r < 70)      b = 8'($urandom_range(32, 127));
    else if (r < 76) b = 8'h0D;
    else if (r < 83) b = 8'h0A;
    else if (r < 91) b = 8'h08;
    else if (r < 93) b = 8'h0C;
    else if (r < 97) b = 8'($urandom_range(128, 255));
    else begin
      b = 8'($urandom_range(0, 31));
      if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h1B;
    end
    return b;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] d;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.rd_addr  = '0;
    reset_n      = 1'b0;
    mdl_clear();

    repeat (3) @(negedge clk_sys);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_redraw", bus.redraw, 0);
    check("rst_col", bus.cursor_col, 0);
    check("rst_row", bus.cursor_row, 0);
    check("rst_rd_data", bus.rd_data, 0);

    reset_n = 1'b1;
    wait_clear("init_clear_cycles");
    check("init_in_ready", bus.in_ready, 1);
    check_mem("init_clear");

    // Single printable character
    send(8'h41);
    read_cell(0, d);
    check("cell0_A", d, 8'h21);
    check_cursor("after_A");

    // Full row of 'x' wraps to the next row; BS at col 0 is a no-op
    send(8'h0C);
    repeat (COLS) send(8'h78);
    check_cursor("row_wrap");
    check_mem("row_of_x");
    send(8'h08);
    check_cursor("bs_col0");

    // 'Q' at row 1 col 0, then fill to the last cell to force a scroll
    send(8'h51);
    repeat (CELLS - COLS - 1) send(8'h5A);
    check_cursor("after_scroll");
    read_cell(0, d);
    check("cell0_Q_scrolled", d, 8'h31);
    check_mem("after_scroll");

    // Backspace erases; form feed clears
    send(8'h0C);
    send(8'h41);
    send(8'h08);
    read_cell(0, d);
    check("cell0_erased", d, 8'h00);
    check_cursor("after_bs");
    send(8'h0C);
    check_cursor("after_ff");

    // Reset in the middle of a scroll
    repeat (20) send(8'h0A);
    send(8'h48);
    send(8'h49);
    repeat (9) send(8'h0A);
    check_cursor("pre_scroll");
    bus.in_data  = 8'h0A;
    bus.in_valid = 1'b1;
    @(negedge clk_sys);
    bus.in_valid = 1'b0;
    repeat (499) @(negedge clk_sys);
    check("busy_mid_scroll", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1);
    check("midrst_col", bus.cursor_col, 0);
    check("midrst_row", bus.cursor_row, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    mdl_clear();
    wait_clear("midrst_clear_cycles");
    check_mem("after_midrst");
    check_cursor("after_midrst");
    send(8'h07);
    send(8'h9A);
    check_cursor("ignored_bytes");

    // Randomised traffic
    for (int i = 0; i < 250; i++) send(rand_byte());
    check_cursor("random");
    check_mem("random");

    // Out-of-range renderer addresses read as zero
    read_cell(CELLS, d);
    check("rd_oob_1200", d, 8'h00);
    read_cell(2047, d);
    check("rd_oob_2047", d, 8'h00);

    check("scoreboard_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
